// File: rtl/fft_result_checker_if.sv
// AXI4-Stream style bus carrying FFT output beats into the result checker.
interface fft_result_checker_if #(
  parameter int DATA_W = 16,
  parameter int LOG2_N = 8
);
  logic                  tvalid;
  logic                  tready;
  logic [2*DATA_W-1:0]   tdata;
  logic                  tlast;
  logic [LOG2_N-1:0]     tuser;

  modport master (output tvalid, tdata, tlast, tuser, input tready);
  modport slave  (input tvalid, tdata, tlast, tuser, output tready);
endinterface

// File: rtl/fft_result_checker.sv
// Sink for FFT output frames: tracks the per-frame peak bin, checks framing,
// judges each frame and drives the pass LED. FFT_CHK_MIRROR_EN also accepts bin N-EXP_BIN.
module fft_result_checker #(
  parameter int DATA_W     = 16,
  parameter int LOG2_N     = 8,
  parameter int EXP_BIN    = 16,
  parameter int MAG_THRESH = 1000
) (
  input  logic                clk,
  input  logic                rst,
  fft_result_checker_if.slave s_axis_data,
  output logic                frame_done,
  output logic                frame_pass,
  output logic [LOG2_N-1:0]   peak_bin,
  output logic [DATA_W:0]     peak_mag,
  output logic [7:0]          err_cnt,
  output logic [15:0]         frame_cnt,
  output logic                led
);
  localparam int N = 1 << LOG2_N;
  localparam logic [LOG2_N-1:0] EXP_B  = LOG2_N'(EXP_BIN);
  localparam logic [LOG2_N-1:0] MIR_B  = LOG2_N'(N - EXP_BIN);
  localparam logic [DATA_W:0]   THRESH = (DATA_W+1)'(MAG_THRESH);

  typedef enum logic [1:0] {IDLE, RECV, EVAL, REPORT} state_t;
  state_t state, state_nx;

  logic [LOG2_N:0]     cnt;
  logic [LOG2_N-1:0]   idx;
  logic [LOG2_N-1:0]   cur_bin;
  logic [DATA_W:0]     cur_mag;
  logic                ferr;
  logic                pass_r;
  logic                failed;
  logic                rdy;
  logic                accept;
  logic                last_idx;
  logic                close;
  logic                beat_err;
  logic                bin_ok;
  logic [DATA_W-1:0]   re, im, abs_re, abs_im;
  logic [DATA_W:0]     mag;

  assign s_axis_data.tready = rdy;
  assign accept   = s_axis_data.tvalid && rdy;
  assign idx      = (state == IDLE) ? '0 : cnt[LOG2_N-1:0];
  assign last_idx = (idx == '1);
  assign close    = accept && (s_axis_data.tlast || last_idx);
  assign beat_err = (s_axis_data.tuser != idx) || (s_axis_data.tlast != last_idx);

  // Unsigned negate makes the most negative input come out as 2^(DATA_W-1).
  assign re     = s_axis_data.tdata[DATA_W-1:0];
  assign im     = s_axis_data.tdata[2*DATA_W-1:DATA_W];
  assign abs_re = re[DATA_W-1] ? (~re + 1'b1) : re;
  assign abs_im = im[DATA_W-1] ? (~im + 1'b1) : im;
  assign mag    = {1'b0, abs_re} + {1'b0, abs_im};

`ifdef FFT_CHK_MIRROR_EN
  assign bin_ok = (cur_bin == EXP_B) || (cur_bin == MIR_B);
`else
  assign bin_ok = (cur_bin == EXP_B);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    rdy      = 1'b0;
    case (state)
      IDLE: begin
        rdy = 1'b1;
        if (accept) state_nx = close ? EVAL : RECV;
      end
      RECV: begin
        rdy = 1'b1;
        if (close) state_nx = EVAL;
      end
      EVAL:    state_nx = REPORT;
      REPORT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      cur_bin    <= '0;
      cur_mag    <= '0;
      ferr       <= 1'b0;
      pass_r     <= 1'b0;
      failed     <= 1'b0;
      frame_done <= 1'b0;
      frame_pass <= 1'b0;
      peak_bin   <= '0;
      peak_mag   <= '0;
      err_cnt    <= '0;
      frame_cnt  <= '0;
      led        <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (accept) begin
        cnt <= (state == IDLE) ? (LOG2_N+1)'(1) : cnt + 1'b1;
        // Strict compare keeps the earliest bin on ties; first beat always seeds.
        if (state == IDLE || mag > cur_mag) begin
          cur_mag <= mag;
          cur_bin <= s_axis_data.tuser;
        end
        ferr <= ((state == IDLE) ? 1'b0 : ferr) | beat_err;
      end
      if (state == EVAL)
        pass_r <= !ferr && bin_ok && (cur_mag >= THRESH);
      if (state == REPORT) begin
        frame_done <= 1'b1;
        frame_pass <= pass_r;
        peak_bin   <= cur_bin;
        peak_mag   <= cur_mag;
        frame_cnt  <= frame_cnt + 1'b1;
        if (!pass_r) begin
          if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
          failed <= 1'b1;
          led    <= 1'b0;
        end else begin
          led <= !failed;
        end
      end
    end
  end
endmodule

// File: doc/fft_result_checker.md
Name: fft_result_checker

Overview:
- Stream sink at the far end of the burst FFT/IFFT path in the FFT test top.
- Consumes FFT output frames (AXI4-Stream style) and tracks the peak-magnitude bin per frame.
- Checks framing (index and tlast), compares the peak against the expected tone bin and threshold, and drives the board pass LED.
- Provides the result side of the self-checking FFT test; the stimulus generator is the other end.

Parameters:
- DATA_W, 16, width of each real/imag component (signed)
- LOG2_N, 8, log2 of FFT length N (N=256)
- EXP_BIN, 16, expected peak bin index
- MAG_THRESH, 1000, minimum peak magnitude for pass (unsigned, DATA_W+1 bits)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- s_axis_data_tvalid  in  1  output beat valid
- s_axis_data_tready  out  1  checker ready
- s_axis_data_tdata  in  2*DATA_W  {imag, real}, real in LSBs, two's complement
- s_axis_data_tlast  in  1  last beat of frame
- s_axis_data_tuser  in  LOG2_N  bin index of beat
- frame_done  out  1  one-cycle pulse, frame result valid
- frame_pass  out  1  result of last frame
- peak_bin  out  LOG2_N  peak bin of last frame
- peak_mag  out  DATA_W+1  peak magnitude of last frame
- err_cnt  out  8  failed-frame count, saturates at 255
- frame_cnt  out  16  completed-frame count, wraps
- led  out  1  1 = at least one frame done and no frame ever failed

Behaviour:
- Reset: all outputs 0 except tready=1; FSM to IDLE; any partial frame discarded.
- Beat accepted on tvalid && tready. tready=1 in IDLE/RECV, 0 in EVAL/REPORT.
- Magnitude = |re|+|im|, computed in DATA_W+1 bits unsigned. -2^(DATA_W-1) gives abs 2^(DATA_W-1) with no overflow.
- FSM:
  - IDLE: first accepted beat loads beat counter=1, runs peak/framing logic on that beat, then goes to RECV. If tlast is set on that beat, go straight to EVAL.
  - RECV: each accepted beat increments the counter. Frame closes on the beat where tlast=1 or counter reaches N, whichever comes first, then go to EVAL.
  - EVAL (1 cycle): compute pass.
  - REPORT (1 cycle): update outputs, pulse frame_done, go to IDLE.
- Peak: updated only when mag is strictly greater than the current peak. Ties keep the lower (earlier) bin. Peak is initialised per frame from the first beat.
- Framing error (sticky within frame):
  - tuser != beat index (0-based)
  - tlast asserted before beat N-1
  - tlast missing on beat N-1
- pass = no framing error && peak_bin==EXP_BIN && peak_mag>=MAG_THRESH.
- Latency: frame_done asserts 2 cycles after the closing beat handshake.
- peak_bin, peak_mag and frame_pass hold until the next frame_done.
- On a failed frame, err_cnt increments (saturating) and led clears. led never re-asserts until reset.
- frame_cnt increments on every frame_done.
- tvalid during EVAL/REPORT is not accepted; the upstream holds the beat (standard AXIS).

Optional Feature:
- Macro: FFT_CHK_MIRROR_EN.
- Defined: bin N-EXP_BIN (mod N) is also accepted as the expected peak, covering the conjugate image of a real-input tone.
- Undefined: only EXP_BIN passes.

Test Plan:
- Clean frame (N=256): bin16 = re 2000 / im -500, all other bins re 10 / im 0, tlast on beat 255 → frame_done 2 cycles after the last beat; peak_bin=16, peak_mag=2500, frame_pass=1, led=1, err_cnt=0, frame_cnt=1.
- Wrong peak at bin 40 (mag 2500), followed by a clean frame → first frame pass=0, err_cnt=1, led=0; led stays 0 after the clean second frame, frame_cnt=2.
- tlast on beat 100 with the tone at bin 16 → frame closes after 101 beats; pass=0, peak_bin=16, err_cnt=1. The next beat starts a new frame in IDLE.
- Tie: bins 16 and 20 both mag 2500 → peak_bin=16, pass=1. Random tvalid gaps in the same frame give identical results. tready is observed low for exactly 2 cycles after the closing beat.
- Reset asserted at beat 128 of a frame, then a full clean frame → all counters 0 after reset; the clean frame gives pass=1, frame_cnt=1, led=1.
- Peak at bin 240, mag 3000 → pass=1 with FFT_CHK_MIRROR_EN defined; pass=0 and err_cnt=1 without it.
